// File: rtl/alu_result_demux_if.sv
// Handshake bundle for alu_result_demux: one tagged upstream stream in, NCHAN
// independent valid/ready channels out, plus the busy indication.
interface alu_result_demux_if #(
    parameter int WIDTH = 32,
    parameter int NCHAN = 8,
    parameter int SEL_W = 3
);
    logic                     in_valid;
    logic                     in_ready;
    logic [SEL_W-1:0]         in_sel;
    logic [WIDTH-1:0]         in_data;
    logic [NCHAN-1:0]         out_valid;
    logic [NCHAN-1:0]         out_ready;
    logic [NCHAN*WIDTH-1:0]   out_data;
    logic                     busy;

    modport master (
        output in_valid, in_sel, in_data, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_sel, in_data, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/alu_result_demux.sv
// 1-to-NCHAN result distributor: 2-entry in-order FIFO feeding one holding register per channel.
// Optional DEMUX_COUNT_EN adds a saturating 16-bit channel-handshake counter (xfer_count).
//
// state    | meaning
// ST_EMPTY | FIFO holds no words
// ST_ONE   | FIFO holds one word (head only)
// ST_FULL  | FIFO holds two words, upstream is stalled
module alu_result_demux #(
    parameter int WIDTH = 32,
    parameter int NCHAN = 8,
    parameter int SEL_W = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_result_demux_if.slave  bus
`ifdef DEMUX_COUNT_EN
    ,
    output logic [15:0]        xfer_count
`endif
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t             r_state;
    logic               r_up;
    logic               r_wr_ptr;
    logic               r_rd_ptr;
    logic [SEL_W-1:0]   r_fifo_sel  [2];
    logic [WIDTH-1:0]   r_fifo_data [2];
    logic [NCHAN-1:0]   r_out_valid;
    logic [WIDTH-1:0]   r_out_data  [NCHAN];

    logic               w_in_ready;
    logic               w_push;
    logic               w_pop;
    logic               w_head_free;
    logic [SEL_W-1:0]   w_head_sel;
    logic [WIDTH-1:0]   w_head_data;
    logic [NCHAN-1:0]   w_disp_vec;
    logic [NCHAN-1:0]   w_hs_vec;
    logic [NCHAN*WIDTH-1:0] w_out_data;

    // r_up keeps in_ready low until the first edge after reset release.
    assign w_in_ready  = r_up && (r_state != ST_FULL);
    assign w_push      = bus.in_valid && w_in_ready;
    assign w_head_sel  = r_fifo_sel[r_rd_ptr];
    assign w_head_data = r_fifo_data[r_rd_ptr];
    assign w_head_free = !r_out_valid[w_head_sel] || bus.out_ready[w_head_sel];
    assign w_pop       = (r_state != ST_EMPTY) && w_head_free;
    assign w_disp_vec  = w_pop ? (NCHAN'(1) << w_head_sel) : '0;
    assign w_hs_vec    = r_out_valid & bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_EMPTY;
            r_up           <= 1'b0;
            r_wr_ptr       <= 1'b0;
            r_rd_ptr       <= 1'b0;
            r_fifo_sel[0]  <= '0;
            r_fifo_sel[1]  <= '0;
            r_fifo_data[0] <= '0;
            r_fifo_data[1] <= '0;
        end else begin
            r_up <= 1'b1;
            if (w_push) begin
                r_fifo_sel[r_wr_ptr]  <= bus.in_sel;
                r_fifo_data[r_wr_ptr] <= bus.in_data;
                r_wr_ptr              <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case (r_state)
                ST_EMPTY: begin
                    if (w_push) r_state <= ST_ONE;
                end
                ST_ONE: begin
                    if (w_push && !w_pop)      r_state <= ST_FULL;
                    else if (!w_push && w_pop) r_state <= ST_EMPTY;
                end
                ST_FULL: begin
                    if (w_pop) r_state <= ST_ONE;
                end
                default: r_state <= ST_EMPTY;
            endcase
        end
    end

    // A dispatch wins over a same-edge handshake so back-to-back words keep valid high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= '0;
            for (int i = 0; i < NCHAN; i++) begin
                r_out_data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCHAN; i++) begin
                if (w_disp_vec[i]) begin
                    r_out_valid[i] <= 1'b1;
                    r_out_data[i]  <= w_head_data;
                end else if (w_hs_vec[i]) begin
                    r_out_valid[i] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        w_out_data = '0;
        for (int i = 0; i < NCHAN; i++) begin
            w_out_data[i*WIDTH +: WIDTH] = r_out_data[i];
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = w_out_data;
    assign bus.busy      = (r_state != ST_EMPTY) || (|r_out_valid);

    always @(posedge clk) begin
        if (rst_n) begin
            assert (r_state inside {ST_EMPTY, ST_ONE, ST_FULL});
            assert (!(w_push && r_state == ST_FULL));
            assert (!(w_pop && r_state == ST_EMPTY));
        end
    end

`ifdef DEMUX_COUNT_EN
    localparam int CW = $clog2(NCHAN + 1);

    logic [15:0]   r_xfer_count;
    logic [CW-1:0] w_hs_num;
    logic [16:0]   w_cnt_sum;

    always_comb begin
        w_hs_num = '0;
        for (int i = 0; i < NCHAN; i++) begin
            w_hs_num = w_hs_num + CW'(w_hs_vec[i]);
        end
    end

    assign w_cnt_sum = {1'b0, r_xfer_count} + 17'(w_hs_num);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_xfer_count <= '0;
        end else if (w_cnt_sum[16]) begin
            r_xfer_count <= 16'hFFFF;
        end else begin
            r_xfer_count <= w_cnt_sum[15:0];
        end
    end

    assign xfer_count = r_xfer_count;
`endif

endmodule
